// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller for the 5-stage MIPS core: load-use and branch-operand
// stalls, multi-cycle load stall, memory wait-state freeze, branch flush and statistics.
module hazard_control_unit #(
    parameter int REG_W      = 5,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             rt_used_id,
    input  logic             branch_id,
    input  logic             branch_taken_id,
    input  logic             mem_read_ex,
    input  logic             reg_write_ex,
    input  logic [REG_W-1:0] write_reg_ex,
    input  logic             mem_read_mem,
    input  logic [REG_W-1:0] write_reg_mem,
    input  logic             mem_ready,
    input  logic             mem_access_mem,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LSTALL = 2'd1,
        ST_MWAIT  = 2'd2
    } state_t;

    localparam logic [3:0]       LS_INIT  = 4'(LOAD_STALL - 1);
    localparam logic [REG_W-1:0] REG_ZERO = {REG_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             saved_ls_q, saved_ls_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic ex_rs_s, ex_rt_s, mem_rs_s, mem_rt_s;
    logic load_use_s, br_ex_s, br_mem_s, mem_wait_s;
    logic pc_write_s, if_id_write_s, bubble_s, flush_s, freeze_s;

    // Hazard detection; register 0 is never a real dependency.
    always_comb begin
        ex_rs_s    = (write_reg_ex != REG_ZERO) && (write_reg_ex == rs_id);
        ex_rt_s    = (write_reg_ex != REG_ZERO) && (write_reg_ex == rt_id);
        mem_rs_s   = (write_reg_mem != REG_ZERO) && (write_reg_mem == rs_id);
        mem_rt_s   = (write_reg_mem != REG_ZERO) && (write_reg_mem == rt_id);
        load_use_s = mem_read_ex && (ex_rs_s || (rt_used_id && ex_rt_s));
        br_ex_s    = branch_id && reg_write_ex && !mem_read_ex && (ex_rs_s || ex_rt_s);
        br_mem_s   = branch_id && mem_read_mem && (mem_rs_s || mem_rt_s);
        mem_wait_s = mem_access_mem && !mem_ready;
    end

    // Next-state and control-output decode; freeze beats stall beats flush.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        saved_ls_d    = saved_ls_q;
        pc_write_s    = 1'b1;
        if_id_write_s = 1'b1;
        bubble_s      = 1'b0;
        flush_s       = 1'b0;
        freeze_s      = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_wait_s) begin
                    pc_write_s    = 1'b0;
                    if_id_write_s = 1'b0;
                    freeze_s      = 1'b1;
                    saved_ls_d    = 1'b0;
                    state_d       = ST_MWAIT;
                end else if (load_use_s) begin
                    pc_write_s    = 1'b0;
                    if_id_write_s = 1'b0;
                    bubble_s      = 1'b1;
                    if (LOAD_STALL > 1) begin
                        state_d = ST_LSTALL;
                        cnt_d   = LS_INIT;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (br_ex_s || br_mem_s) begin
                    pc_write_s    = 1'b0;
                    if_id_write_s = 1'b0;
                    bubble_s      = 1'b1;
                end else if (branch_taken_id) begin
                    flush_s = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LSTALL: begin
                pc_write_s    = 1'b0;
                if_id_write_s = 1'b0;
                if (mem_wait_s) begin
                    freeze_s   = 1'b1;
                    saved_ls_d = 1'b1;
                    state_d    = ST_MWAIT;
                end else begin
                    bubble_s = 1'b1;
                    cnt_d    = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_LSTALL;
                    end
                end
            end
            ST_MWAIT: begin
                pc_write_s    = 1'b0;
                if_id_write_s = 1'b0;
                freeze_s      = 1'b1;
                if (mem_ready) begin
                    state_d = saved_ls_q ? ST_LSTALL : ST_RUN;
                end else begin
                    state_d = ST_MWAIT;
                end
            end
            default: begin
                state_d    = ST_RUN;
                cnt_d      = 4'd0;
                saved_ls_d = 1'b0;
            end
        endcase
    end

    // Saturating statistics counters.
    always_comb begin
        if (!pc_write_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State, stall counter and statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            cnt_q       <= 4'd0;
            saved_ls_q  <= 1'b0;
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            saved_ls_q  <= saved_ls_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // While reset is held the pipeline is kept still with a bubble in ID/EX.
    assign pc_write     = !reset && pc_write_s;
    assign if_id_write  = !reset && if_id_write_s;
    assign id_ex_bubble = reset || bubble_s;
    assign if_id_flush  = !reset && flush_s;
    assign pipe_freeze  = !reset && freeze_s;
    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

endmodule
